// File: rtl/timer_pkg.sv
// Shared types and constants for the tick timer.
package timer_pkg;

  // Timer FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } timer_state_t;

  // Default width of the count and load value.
  localparam int unsigned TIMER_WIDTH_DEFAULT = 16;

endpackage

// File: rtl/edge_detect.sv
// Rising-edge detector: registers a level and pulses for one cycle on 0->1.
module edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic d_q;

  // Previous-cycle copy of the input level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign pulse = d & ~d_q;

endmodule

// File: rtl/tick_timer.sv
// Programmable down-counting timer driven by rising edges of the divided clock.
// One-shot or auto-reload expiry, with a one-cycle expiry pulse and sticky irq.
module tick_timer
  import timer_pkg::*;
#(
  parameter int unsigned WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clk_d,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             reload_en,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq
);

  timer_state_t     state;
  logic [WIDTH-1:0] reload_reg;
  logic             tick;
  logic             expire;
  logic             reload_ok;

  edge_detect u_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (clk_d),
    .pulse (tick)
  );

  // A start while already running has no effect, so a tick in that cycle is
  // still counted; load and stop both pre-empt the tick.
  assign expire    = !load && !stop && (state == RUN) && tick && (count == WIDTH'(1));
  assign reload_ok = reload_en && (reload_reg != '0);
  assign running   = (state == RUN);

  // FSM, counter and reload register, in load > stop > start > tick priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
    end else if (load) begin
      reload_reg <= load_val;
      count      <= load_val;
      state      <= IDLE;
    end else if (stop) begin
      if (state == RUN) begin
        state <= IDLE;
      end
    end else if (start && (state != RUN)) begin
      if (state == IDLE) begin
        if (count != '0) begin
          state <= RUN;
        end
      end else if (reload_reg != '0) begin
        count <= reload_reg;
        state <= RUN;
      end
    end else if ((state == RUN) && tick) begin
      if (count > WIDTH'(1)) begin
        count <= count - WIDTH'(1);
      end else if (expire) begin
        if (reload_ok) begin
          count <= reload_reg;
        end else begin
          count <= '0;
          state <= DONE;
        end
      end
    end
  end

  // Expiry pulse and sticky interrupt; a new expiry beats a same-cycle ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      expired <= 1'b0;
      irq     <= 1'b0;
    end else begin
      expired <= expire;
      if (expire) begin
        irq <= 1'b1;
      end else if (irq_ack) begin
        irq <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_tick_timer.sv
// Directed testbench for tick_timer; clk_d is driven as a divide-by-4 waveform.
module tb_tick_timer;

  localparam int unsigned W = 16;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         clk_d = 1'b0;
  logic         load = 1'b0;
  logic [W-1:0] load_val = '0;
  logic         start = 1'b0;
  logic         stop = 1'b0;
  logic         reload_en = 1'b0;
  logic         irq_ack = 1'b0;
  logic [W-1:0] count;
  logic         running;
  logic         expired;
  logic         irq;

  int total = 0;
  int bad = 0;

  tick_timer #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clk_d     (clk_d),
    .load      (load),
    .load_val  (load_val),
    .start     (start),
    .stop      (stop),
    .reload_en (reload_en),
    .irq_ack   (irq_ack),
    .count     (count),
    .running   (running),
    .expired   (expired),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One divided-clock period: high 2 cycles, low 2 cycles (one tick).
  task automatic tick4();
    clk_d = 1'b1;
    cyc(2);
    clk_d = 1'b0;
    cyc(2);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    load = 1'b1;
    load_val = v;
    cyc(1);
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic test_reset();
    cyc(1);
    total++; if (count !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", count); end
    total++; if ({running, expired, irq} !== 3'b000) begin bad++; $display("FAIL reset_flags got=%b exp=000", {running, expired, irq}); end
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic test_one_shot();
    do_load(16'd3);
    total++; if (count !== 16'd3 || running !== 1'b0) begin bad++; $display("FAIL oneshot_load count=%0d run=%b exp=3/0", count, running); end
    do_start();
    total++; if (running !== 1'b1) begin bad++; $display("FAIL oneshot_running got=%b exp=1", running); end
    tick4();
    total++; if (count !== 16'd2) begin bad++; $display("FAIL oneshot_tick1 got=%0d exp=2", count); end
    tick4();
    total++; if (count !== 16'd1 || expired !== 1'b0) begin bad++; $display("FAIL oneshot_tick2 count=%0d exp_pulse=%b exp=1/0", count, expired); end
    clk_d = 1'b1;
    cyc(1);
    total++; if ({expired, irq, running} !== 3'b110 || count !== 16'd0) begin bad++; $display("FAIL oneshot_expiry eir=%b count=%0d exp=110/0", {expired, irq, running}, count); end
    cyc(1);
    total++; if (expired !== 1'b0) begin bad++; $display("FAIL oneshot_pulse_width got=%b exp=0", expired); end
    clk_d = 1'b0;
    cyc(2);
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    total++; if (irq !== 1'b0) begin bad++; $display("FAIL oneshot_ack got=%b exp=0", irq); end
  endtask

  task automatic test_reload();
    reload_en = 1'b1;
    do_load(16'd2);
    do_start();
    for (int i = 0; i < 2; i++) begin
      tick4();
      total++; if (count !== 16'd1 || running !== 1'b1) begin bad++; $display("FAIL reload_dec%0d count=%0d run=%b exp=1/1", i, count, running); end
      clk_d = 1'b1;
      cyc(1);
      total++; if (expired !== 1'b1 || count !== 16'd2 || running !== 1'b1) begin bad++; $display("FAIL reload_exp%0d e=%b count=%0d run=%b exp=1/2/1", i, expired, count, running); end
      cyc(1);
      clk_d = 1'b0;
      cyc(2);
    end
    reload_en = 1'b0;
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    total++; if (running !== 1'b0 || count !== 16'd2) begin bad++; $display("FAIL reload_stop run=%b count=%0d exp=0/2", running, count); end
  endtask

  task automatic test_stop_resume();
    do_load(16'd5);
    do_start();
    tick4();
    tick4();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
    total++; if (running !== 1'b0 || count !== 16'd3) begin bad++; $display("FAIL stop_hold run=%b count=%0d exp=0/3", running, count); end
    repeat (5) tick4();
    total++; if (count !== 16'd3) begin bad++; $display("FAIL stop_discard got=%0d exp=3", count); end
    do_start();
    tick4();
    tick4();
    total++; if (count !== 16'd1) begin bad++; $display("FAIL resume_count got=%0d exp=1", count); end
    clk_d = 1'b1;
    cyc(1);
    total++; if (expired !== 1'b1 || count !== 16'd0 || running !== 1'b0) begin bad++; $display("FAIL resume_expiry e=%b count=%0d run=%b exp=1/0/0", expired, count, running); end
    clk_d = 1'b0;
    cyc(3);
    // stop and start together while running: stop wins
    do_load(16'd9);
    do_start();
    stop = 1'b1;
    start = 1'b1;
    cyc(1);
    stop = 1'b0;
    start = 1'b0;
    total++; if (running !== 1'b0) begin bad++; $display("FAIL stop_start_same got=%b exp=0", running); end
  endtask

  task automatic test_collisions();
    do_load(16'd1);
    do_start();
    clk_d = 1'b1;
    irq_ack = 1'b1;
    cyc(1);
    irq_ack = 1'b0;
    total++; if (irq !== 1'b1 || expired !== 1'b1) begin bad++; $display("FAIL ack_vs_set irq=%b e=%b exp=1/1", irq, expired); end
    clk_d = 1'b0;
    cyc(2);
    load = 1'b1;
    load_val = 16'd4;
    start = 1'b1;
    clk_d = 1'b1;
    cyc(1);
    load = 1'b0;
    start = 1'b0;
    total++; if (count !== 16'd4 || running !== 1'b0) begin bad++; $display("FAIL load_wins count=%0d run=%b exp=4/0", count, running); end
    cyc(1);
    clk_d = 1'b0;
    cyc(2);
    tick4();
    total++; if (count !== 16'd4) begin bad++; $display("FAIL idle_discard got=%0d exp=4", count); end
  endtask

  task automatic test_zero_and_done();
    do_load(16'd0);
    do_start();
    total++; if (running !== 1'b0 || count !== 16'd0) begin bad++; $display("FAIL zero_start run=%b count=%0d exp=0/0", running, count); end
    do_load(16'd3);
    do_start();
    repeat (3) tick4();
    total++; if (running !== 1'b0 || count !== 16'd0) begin bad++; $display("FAIL done_reach run=%b count=%0d exp=0/0", running, count); end
    do_start();
    total++; if (running !== 1'b1 || count !== 16'd3) begin bad++; $display("FAIL done_restart run=%b count=%0d exp=1/3", running, count); end
    tick4();
    total++; if (count !== 16'd2) begin bad++; $display("FAIL done_restart_tick got=%0d exp=2", count); end
  endtask

  task automatic test_reset_midcount();
    do_load(16'd7);
    do_start();
    total++; if (irq !== 1'b1 || running !== 1'b1 || count !== 16'd7) begin bad++; $display("FAIL pre_reset irq=%b run=%b count=%0d exp=1/1/7", irq, running, count); end
    rst_n = 1'b0;
    #1;
    total++; if (count !== 16'd0 || {irq, expired, running} !== 3'b000) begin bad++; $display("FAIL async_reset count=%0d flags=%b exp=0/000", count, {irq, expired, running}); end
    cyc(1);
    rst_n = 1'b1;
    do_load(16'd5);
    tick4();
    tick4();
    total++; if (count !== 16'd5 || running !== 1'b0 || expired !== 1'b0) begin bad++; $display("FAIL post_reset_idle count=%0d run=%b e=%b exp=5/0/0", count, running, expired); end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_reload();
    test_stop_resume();
    test_collisions();
    test_zero_and_done();
    test_reset_midcount();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tick_timer.md
# tick_timer

Programmable down-counting timer that runs off the divided clock produced by the clock divider. It sits directly downstream of the divider. It samples the divided clock level in the fast `clk` domain and turns each rising edge into a one-cycle tick. It counts ticks down from a loaded value and raises an expiry pulse plus a sticky interrupt, with one-shot or auto-reload behaviour.

## Interface
Parameters:
- WIDTH, 16, width of the count and load value

Ports:
- clk  in  1  system clock; the same clock that drives the divider
- rst_n  in  1  asynchronous, active-low reset
- clk_d  in  1  divided-clock level from the divider, already registered in the `clk` domain
- load  in  1  one-cycle strobe that loads `load_val`
- load_val  in  WIDTH  start and reload value
- start  in  1  one-cycle strobe that begins or resumes counting
- stop  in  1  one-cycle strobe that pauses counting
- reload_en  in  1  1 = auto-reload on expiry, 0 = one-shot
- irq_ack  in  1  clears `irq`
- count  out  WIDTH  current count
- running  out  1  high while in RUN
- expired  out  1  one-cycle pulse on expiry
- irq  out  1  sticky expiry flag

## Operation
- Edge detect: `clk_d_q <= clk_d` and `tick = clk_d & ~clk_d_q`. With the divide-by-4 divider, this gives one tick every 4 `clk` cycles.
- Registers: `reload_reg` (WIDTH), `count` (WIDTH), `state`, `irq`, `expired`.
- States: IDLE, RUN, DONE.
- Priority per cycle: `load` > `stop` > `start` > tick.
- `load` (any state): `reload_reg <= load_val`, `count <= load_val`, state -> IDLE. Any tick in the same cycle is ignored.
- `start`:
  - IDLE with count != 0 -> RUN.
  - IDLE with count == 0 -> ignored.
  - DONE with reload_reg != 0 -> count <= reload_reg, RUN.
  - DONE with reload_reg == 0 -> ignored.
  - RUN -> no effect.
- `stop`: RUN -> IDLE with count held. In other states it has no effect. If `stop` and `start` arrive together, `stop` wins.
- RUN on tick:
  - count > 1: `count <= count - 1`.
  - count == 1: expiry. Set `expired` for one cycle and set `irq`.
    - reload_en = 1 and reload_reg != 0: count <= reload_reg, stay in RUN.
    - Otherwise: count <= 0, go to DONE.
- RUN without a tick: hold.
- Arithmetic: count never wraps. The decrement happens only when count > 1.
- `irq`: set on expiry, cleared on `irq_ack`. If set and ack occur in the same cycle, set wins.
- `running` = (state == RUN).

## Timing
- Reset (async assert; sync release on `clk`): count = 0, reload_reg = 0, state = IDLE, clk_d_q = 0, expired = 0, irq = 0, running = 0.
- A tick is combinational in the cycle where `clk_d` = 1 and `clk_d_q` = 0. The count update becomes visible on the next `clk` edge.
- `expired`, `irq`, and the new count all appear in the same cycle, one clock after the tick cycle of the expiry.
- Load N, then start: expiry occurs on the Nth tick after entering RUN.
- `running` goes high one cycle after the `start` strobe.
- Reset asserted mid-count: everything returns to reset values immediately, and no expiry pulse is produced.
- A stop/start gap does not lose or gain ticks. Ticks that occur while not in RUN are discarded.

## Structure
- Package `timer_pkg`: the `timer_state_t` enum (IDLE, RUN, DONE) and a default width constant.
- Sub-module `edge_detect`: one flop plus the rising-edge pulse, with async active-low reset. Instantiated once for `clk_d`.
- The FSM, counter, and irq logic all live in `tick_timer`.

## Test plan
- Reset, load 3, start; divider running (tick every 4 clk) -> count goes 3, 2, 1, 0; `expired` is high for 1 cycle at the third tick; `irq` = 1; `running` = 0; state DONE. Then `irq_ack` -> `irq` = 0.
- Load 2, reload_en = 1, start -> `expired` pulses every 2 ticks (8 clk cycles), count alternates 2, 1, 2, 1, and `running` stays 1.
- Load 5, start, then stop after 2 ticks -> count holds at 3 for 20 clk cycles. Start again -> reaches expiry 3 ticks later.
- Drive `irq_ack` in the same cycle as expiry with `irq` already 1 -> `irq` remains 1. Drive load 4 in the same cycle as `start` and a tick -> count = 4, state IDLE.
- Load 0, start -> stays IDLE with `running` = 0. From DONE after load 3, start -> count = 3, RUN.
- Assert `rst_n` low while in RUN with count 7 -> count, `irq`, `expired`, and `running` are all 0 immediately. After release, no ticks are counted until `start`.
